// File: rtl/fb_write_queue.sv
// fb_write_queue: receives pixels from the draw engines, range-checks them,
// maps them to back-buffer SRAM addresses and queues them in a FIFO that is
// drained into the SRAM controller's write slots.
module fb_write_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        program_x,
  input  logic [9:0]        program_y,
  input  logic [DATA_W-1:0] program_data,
  input  logic              program_write,
  output logic              program_ready,
  input  logic              current_frame,
  input  logic              sram_wr_slot,
  output logic              sram_wr_req,
  output logic [19:0]       sram_wr_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  output logic              queue_empty,
  output logic [7:0]        drop_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [9:0]            X_LIM    = H_RES[9:0];
  localparam logic [9:0]            Y_LIM    = V_RES[9:0];

  // Saturating increment so the drop counter sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [19:0]           addr_mem [DEPTH];
  logic [DATA_W-1:0]     data_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   occ;

  logic in_range;
  logic push;
  logic pop;
  logic drop;

  assign in_range      = (program_x < X_LIM) && (program_y < Y_LIM);
  // Ready depends only on registered occupancy: a full queue refuses a push
  // even when a pop happens in the same cycle.
  assign program_ready = (occ != OCC_FULL);
  assign sram_wr_req   = (occ != '0);
  assign queue_empty   = (occ == '0);
  assign push          = program_write && program_ready && in_range;
  assign drop          = program_write && !(program_ready && in_range);
  assign pop           = sram_wr_req && sram_wr_slot;

  assign sram_wr_addr  = sram_wr_req ? addr_mem[rd_ptr] : '0;
  assign sram_wr_data  = sram_wr_req ? data_mem[rd_ptr] : '0;

  // Entry storage; the frame bit is captured at accept time so later frame
  // flips do not retarget queued pixels.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= {~current_frame, program_y[8:0], program_x};
      data_mem[wr_ptr] <= program_data;
    end
  end

  // Pointers, occupancy and drop counter; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
      if (drop) drop_count <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Testbench for fb_write_queue: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_fb_write_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        program_ready;
  logic        current_frame;
  logic        sram_wr_slot;
  logic        sram_wr_req;
  logic [19:0] sram_wr_addr;
  logic [15:0] sram_wr_data;
  logic        queue_empty;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {address, data}, plus a drop counter.
  logic [35:0] mq[$];
  int          mdrop = 0;
  int          mpops = 0;

  fb_write_queue #(.DEPTH_LOG2(4), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset(reset),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write), .program_ready(program_ready),
    .current_frame(current_frame), .sram_wr_slot(sram_wr_slot),
    .sram_wr_req(sram_wr_req), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .queue_empty(queue_empty),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, w;
    logic [9:0]  x, y;
    logic [15:0] d;
    logic        f, s;
    logic        e_req;
    logic [19:0] e_addr;
    logic [15:0] e_data;
    logic        e_ready, e_empty;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [9:0] x, input logic [9:0] y,
                       input logic [15:0] d, input logic f, input logic s);
    reset = r; program_write = w; program_x = x; program_y = y;
    program_data = d; current_frame = f; sram_wr_slot = s;
  endtask

  // One clock with model update and full output comparison after the edge.
  task automatic step(input logic r, input logic w, input logic [9:0] x, input logic [9:0] y,
                      input logic [15:0] d, input logic f, input logic s);
    bit m_ready, m_req, inr;
    logic [35:0] h;
    drive(r, w, x, y, d, f, s);
    m_ready = (mq.size() < 16);
    m_req   = (mq.size() != 0);
    @(posedge clk);
    if (r) begin
      mq.delete();
      mdrop = 0;
    end else begin
      inr = (x < 640) && (y < 480);
      if (m_req && s) begin
        h = mq.pop_front();
        mpops++;
      end
      if (w && m_ready && inr) mq.push_back({~f, y[8:0], x, d});
      else if (w) mdrop = (mdrop == 255) ? 255 : mdrop + 1;
    end
    #1;
    h = (mq.size() != 0) ? mq[0] : 36'h0;
    check("req",   32'(sram_wr_req),   32'(mq.size() != 0));
    check("addr",  32'(sram_wr_addr),  32'(h[35:16]));
    check("data",  32'(sram_wr_data),  32'(h[15:0]));
    check("ready", 32'(program_ready), 32'(mq.size() < 16));
    check("empty", 32'(queue_empty),   32'(mq.size() == 0));
    check("drop",  32'(drop_count),    32'(mdrop));
  endtask

  initial begin
    // Directed vectors: reset, single pixel, range check, frame switch.
    vt[0] = '{1'b1, 1'b0, 10'd0,   10'd0,   16'h0000, 1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, 8'd0};
    vt[1] = '{1'b0, 1'b1, 10'd5,   10'd3,   16'hABCD, 1'b0, 1'b0, 1'b1, 20'h80C05, 16'hABCD, 1'b1, 1'b0, 8'd0};
    vt[2] = '{1'b0, 1'b0, 10'd0,   10'd0,   16'h0000, 1'b0, 1'b1, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, 8'd0};
    vt[3] = '{1'b0, 1'b1, 10'd640, 10'd0,   16'h1111, 1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, 8'd1};
    vt[4] = '{1'b0, 1'b1, 10'd0,   10'd480, 16'h2222, 1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, 8'd2};
    vt[5] = '{1'b0, 1'b1, 10'd639, 10'd479, 16'h1234, 1'b0, 1'b0, 1'b1, 20'hF7E7F, 16'h1234, 1'b1, 1'b0, 8'd2};
    vt[6] = '{1'b0, 1'b1, 10'd1,   10'd1,   16'h5555, 1'b1, 1'b1, 1'b1, 20'h00401, 16'h5555, 1'b1, 1'b0, 8'd2};
    vt[7] = '{1'b0, 1'b0, 10'd0,   10'd0,   16'h0000, 1'b0, 1'b0, 1'b1, 20'h00401, 16'h5555, 1'b1, 1'b0, 8'd2};
    vt[8] = '{1'b0, 1'b0, 10'd0,   10'd0,   16'h0000, 1'b0, 1'b1, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, 8'd2};

    drive(1'b1, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].r, vt[i].w, vt[i].x, vt[i].y, vt[i].d, vt[i].f, vt[i].s);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_req", i),   32'(sram_wr_req),   32'(vt[i].e_req));
      check($sformatf("vec%0d_addr", i),  32'(sram_wr_addr),  32'(vt[i].e_addr));
      check($sformatf("vec%0d_data", i),  32'(sram_wr_data),  32'(vt[i].e_data));
      check($sformatf("vec%0d_ready", i), 32'(program_ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d_empty", i), 32'(queue_empty),   32'(vt[i].e_empty));
      check($sformatf("vec%0d_drop", i),  32'(drop_count),    32'(vt[i].e_drop));
    end

    // Fill to full: 17 pushes with no slots, 17th dropped, then drain in order.
    step(1'b1, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 10'(i), 10'd2, 16'(16'h100 + i), 1'b0, 1'b0);
      if (i == 15) check("full_ready", 32'(program_ready), 32'd0);
    end
    check("full_drop", 32'(drop_count), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 32'(sram_wr_data), 32'(16'h100 + i));
      step(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(queue_empty), 32'd1);

    // Full queue with pop and push in the same cycle: push is refused.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 10'(i), 10'd7, 16'(i), 1'b1, 1'b0);
    step(1'b0, 1'b1, 10'd9, 10'd9, 16'hBEEF, 1'b1, 1'b1);
    check("full_pushpop_drop", 32'(drop_count), 32'd2);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 10'd1, 10'd1, 16'h1, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_count), 32'd255);

    // Concurrent push and pop: 100 pixels streamed with slot held high.
    step(1'b1, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b0);
    mpops = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 10'(i), 10'd4, 16'(i), 1'b0, 1'b1);
      check("stream_head", 32'(sram_wr_data), 32'(i));
    end
    step(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b1);
    check("stream_pops", 32'(mpops), 32'd100);
    check("stream_drop", 32'(drop_count), 32'd0);

    // Reset mid-operation with a write present in the reset cycle.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'(i), 10'd5, 16'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'd3, 10'd3, 16'h7777, 1'b0, 1'b0);
    check("rst_empty", 32'(queue_empty), 32'd1);
    check("rst_req",   32'(sram_wr_req), 32'd0);
    check("rst_drop",  32'(drop_count),  32'd0);

    // Randomized traffic with occasional out-of-range coordinates and resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'b0 || ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           10'($urandom_range(0, 700)),
           10'($urandom_range(0, 520)),
           16'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
